// File: rtl/sha3_padder.sv
// SHA3-256 message padder: packs 64-bit words into 1088-bit rate blocks,
// applies 0x06..0x80 padding and paces block issue on the core's hash_next.
module sha3_padder (
    input  logic          clk,
    input  logic          rst,
    input  logic [63:0]   din,
    input  logic          din_valid,
    input  logic          din_last,
    input  logic [3:0]    din_bytes,
    output logic          din_ready,
    output logic [1087:0] blk,
    output logic          blk_valid,
    output logic          blk_more,
    input  logic          hash_next
);

    localparam int unsigned RATE_W     = 1088;
    localparam int unsigned RATE_BYTES = 136;
    localparam int unsigned WCNT_W     = 5;
    localparam int unsigned POS_W      = 8;
    localparam int unsigned IDX_W      = 11;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_PAD  = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [RATE_W-1:0]   buf_q, buf_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic                credit_q, credit_d;
    logic                extra_q, extra_d;
    logic                more_q, more_d;
    logic                blk_valid_q;

    logic                send_c;
    logic                accept_c;
    logic [3:0]          nbytes_c;
    logic [IDX_W-1:0]    base_c;

    assign din_ready = (state_q == ST_FILL) && !rst;
    assign blk       = buf_q;
    assign blk_more  = more_q;
    assign blk_valid = blk_valid_q;

    // Next-state logic for buffer, counters and flags
    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        wcnt_d   = wcnt_q;
        pos_d    = pos_q;
        extra_d  = extra_q;
        more_d   = more_q;
        send_c   = (state_q == ST_SEND) && credit_q;
        accept_c = din_valid && din_ready;
        credit_d = hash_next | (credit_q & ~send_c);
        nbytes_c = din_bytes[3] ? 4'd8 : din_bytes;
        base_c   = {wcnt_q, 6'b000000};

        case (state_q)
            ST_FILL: begin
                if (accept_c) begin
                    for (int j = 0; j < 8; j++) begin
                        if (!din_last || (4'(j) < nbytes_c)) begin
                            buf_d[base_c + IDX_W'(8 * j) +: 8] = din[8*j +: 8];
                        end
                    end
                    if (din_last) begin
                        pos_d   = {wcnt_q, 3'b000} + {4'b0000, nbytes_c};
                        state_d = ST_PAD;
                    end else if (wcnt_q == WCNT_W'(16)) begin
                        more_d  = 1'b1;
                        state_d = ST_SEND;
                    end else begin
                        wcnt_d = wcnt_q + WCNT_W'(1);
                    end
                end
            end
            ST_PAD: begin
                // XOR merge makes p = 135 collapse to the single 0x86 byte
                if (pos_q < POS_W'(RATE_BYTES)) begin
                    buf_d[{pos_q, 3'b000} +: 8] = buf_q[{pos_q, 3'b000} +: 8] ^ 8'h06;
                    buf_d[RATE_W-1 -: 8]        = buf_d[RATE_W-1 -: 8] ^ 8'h80;
                    more_d = 1'b0;
                end else begin
                    more_d  = 1'b1;
                    extra_d = 1'b1;
                end
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (send_c) begin
                    buf_d  = '0;
                    wcnt_d = '0;
                    if (extra_q) begin
                        buf_d[7:0]           = 8'h06;
                        buf_d[RATE_W-1 -: 8] = 8'h80;
                        more_d  = 1'b0;
                        extra_d = 1'b0;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_FILL;
            buf_q       <= '0;
            wcnt_q      <= '0;
            pos_q       <= '0;
            credit_q    <= 1'b1;
            extra_q     <= 1'b0;
            more_q      <= 1'b0;
            blk_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            wcnt_q      <= wcnt_d;
            pos_q       <= pos_d;
            credit_q    <= credit_d;
            extra_q     <= extra_d;
            more_q      <= more_d;
            blk_valid_q <= (state_d == ST_SEND) && credit_d;
        end
    end

endmodule

// File: tb/tb_sha3_padder.sv
// Bench for sha3_padder: byte-level SHA3 padding model, a simple core model
// returning hash_next, and directed messages with literal expectations.
module tb_sha3_padder;

    logic          clk = 1'b0;
    logic          rst;
    logic [63:0]   din;
    logic          din_valid;
    logic          din_last;
    logic [3:0]    din_bytes;
    logic          din_ready;
    logic [1087:0] blk;
    logic          blk_valid;
    logic          blk_more;
    logic          hash_next;

    sha3_padder dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_last  (din_last),
        .din_bytes (din_bytes),
        .din_ready (din_ready),
        .blk       (blk),
        .blk_valid (blk_valid),
        .blk_more  (blk_more),
        .hash_next (hash_next)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int pcyc     = 0;
    int core_delay = 1;
    logic credit_m = 1'b1;

    logic [1087:0] exp_blk_q[$];
    logic          exp_more_q[$];
    logic [1087:0] got_blk[$];
    logic          got_more[$];
    int            got_cyc[$];
    int            word_cyc[$];

    always @(posedge clk) pcyc <= pcyc + 1;

    task automatic chk_val(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s act=%0h req=%0h", nm, act, req);
        end
    endtask

    task automatic chk_blk(input string nm, input logic [1087:0] act, input logic [1087:0] req);
        checks++;
        if (act !== req) begin
            int d;
            d = 0;
            for (int k = 135; k >= 0; k--) if (act[8*k +: 8] !== req[8*k +: 8]) d = k;
            failures++;
            $display("FAIL %s byte%0d act=%h req=%h", nm, d, act[8*d +: 8], req[8*d +: 8]);
        end
    endtask

    // Reference: msg || 0x06 || 0.. || 0x80 to a multiple of 136 bytes, XOR-merged
    task automatic model_msg(input logic [7:0] m[$]);
        int n, len;
        logic [7:0] p[];
        logic [1087:0] b;
        n   = m.size();
        len = (n / 136 + 1) * 136;
        p   = new[len];
        for (int i = 0; i < len; i++) p[i] = (i < n) ? m[i] : 8'h00;
        p[n]     = p[n] ^ 8'h06;
        p[len-1] = p[len-1] ^ 8'h80;
        for (int k = 0; k < len / 136; k++) begin
            for (int i = 0; i < 136; i++) b[8*i +: 8] = p[136*k + i];
            exp_blk_q.push_back(b);
            exp_more_q.push_back(k != len / 136 - 1);
        end
    endtask

    // Compare process: every strobe is checked against the model and the credit rule
    always @(negedge clk) begin
        if (rst) begin
            credit_m = 1'b1;
        end else begin
            if (blk_valid) begin
                chk_val("blk_without_credit", 64'(credit_m), 64'd1);
                chk_val("ready_in_send", 64'(din_ready), 64'd0);
                if (exp_blk_q.size() == 0) begin
                    chk_val("unexpected_blk", 64'd1, 64'd0);
                end else begin
                    chk_blk("blk_data", blk, exp_blk_q.pop_front());
                    chk_val("blk_more", 64'(blk_more), 64'(exp_more_q.pop_front()));
                end
                got_blk.push_back(blk);
                got_more.push_back(blk_more);
                got_cyc.push_back(pcyc);
            end
            credit_m = hash_next | (credit_m & ~blk_valid);
        end
    end

    // Core model: pulse hash_next core_delay cycles after each block
    initial begin
        hash_next = 1'b0;
        forever begin
            @(negedge clk);
            if (blk_valid && !rst) begin
                repeat (core_delay) @(posedge clk);
                #1 hash_next = 1'b1;
                @(posedge clk);
                #1 hash_next = 1'b0;
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge
    task automatic put_word(input logic [63:0] w, input logic last, input logic [3:0] nb);
        int k;
        din       = w;
        din_last  = last;
        din_bytes = nb;
        din_valid = 1'b1;
        k = 0;
        forever begin
            @(negedge clk);
            if (din_ready) begin
                word_cyc.push_back(pcyc);
                @(posedge clk);
                #1;
                break;
            end
            k++;
            if (k > 3000) begin
                chk_val("accept_timeout", 64'd1, 64'd0);
                break;
            end
        end
    endtask

    task automatic drive_msg(input logic [7:0] m[$]);
        int n, nw, b, idx;
        logic [63:0] w;
        n  = m.size();
        nw = (n == 0) ? 1 : (n + 7) / 8;
        word_cyc.delete();
        for (int i = 0; i < nw; i++) begin
            for (int j = 0; j < 8; j++) begin
                idx = 8 * i + j;
                w[8*j +: 8] = (idx < n) ? m[idx] : 8'hAA;
            end
            b = (i == nw - 1) ? n - 8 * i : 8;
            put_word(w, i == nw - 1, 4'(b));
        end
        din_valid = 1'b0;
        din_last  = 1'b0;
    endtask

    task automatic run_msg(input logic [7:0] m[$]);
        int k;
        got_blk.delete();
        got_more.delete();
        got_cyc.delete();
        model_msg(m);
        drive_msg(m);
        k = 0;
        while (exp_blk_q.size() != 0 && k < 5000) begin
            @(posedge clk);
            k++;
        end
        chk_val("drain", 64'(exp_blk_q.size()), 64'd0);
        repeat (core_delay + 5) @(posedge clk);
        #1;
    endtask

    logic [1087:0] lit_pad, lit_abc;
    logic [7:0]    msg[$];

    initial begin
        #3_000_000;
        $display("FAIL watchdog act=timeout req=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        lit_pad = '0;
        lit_pad[7:0]       = 8'h06;
        lit_pad[1087:1080] = 8'h80;
        lit_abc = '0;
        lit_abc[31:0]      = 32'h06636261;
        lit_abc[1087:1080] = 8'h80;

        rst = 1'b1; din = '0; din_valid = 1'b0; din_last = 1'b0; din_bytes = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_blk("rst_blk", blk, '0);
        chk_val("rst_valid", 64'(blk_valid), 64'd0);
        chk_val("rst_more", 64'(blk_more), 64'd0);
        chk_val("rst_ready", 64'(din_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk_val("ready_after_rst", 64'(din_ready), 64'd1);
        @(posedge clk);
        #1;

        // Empty message
        msg.delete();
        run_msg(msg);
        chk_val("empty_nblk", 64'(got_blk.size()), 64'd1);
        chk_blk("empty_lit", got_blk[0], lit_pad);
        chk_val("empty_lat", 64'(got_cyc[0] - word_cyc[0]), 64'd2);

        // "abc"
        msg = {8'h61, 8'h62, 8'h63};
        run_msg(msg);
        chk_blk("abc_lit", got_blk[0], lit_abc);
        chk_val("abc_more", 64'(got_more[0]), 64'd0);
        chk_val("abc_lat", 64'(got_cyc[0] - word_cyc[0]), 64'd2);

        // 135 bytes: padding collapses to 0x86
        msg.delete();
        for (int i = 0; i < 135; i++) msg.push_back(8'(i + 1));
        run_msg(msg);
        chk_val("b135_nblk", 64'(got_blk.size()), 64'd1);
        chk_val("b135_last", 64'(got_blk[0][1087:1080]), 64'h86);
        chk_val("b135_first", 64'(got_blk[0][7:0]), 64'h01);

        // 136 bytes: data block then padding-only block after hash_next
        core_delay = 30;
        msg.delete();
        for (int i = 0; i < 136; i++) msg.push_back(8'(i + 1));
        run_msg(msg);
        chk_val("b136_nblk", 64'(got_blk.size()), 64'd2);
        chk_val("b136_more0", 64'(got_more[0]), 64'd1);
        chk_val("b136_byte135", 64'(got_blk[0][1087:1080]), 64'h88);
        chk_blk("b136_pad_lit", got_blk[1], lit_pad);
        chk_val("b136_more1", 64'(got_more[1]), 64'd0);
        chk_val("b136_gap", 64'(got_cyc[1] - got_cyc[0]), 64'd31);

        // 300 bytes under backpressure
        msg.delete();
        for (int i = 0; i < 300; i++) msg.push_back(8'(i * 7 + 3));
        run_msg(msg);
        chk_val("bp_nblk", 64'(got_blk.size()), 64'd3);
        chk_val("bp_more", 64'({got_more[0], got_more[1], got_more[2]}), 64'b110);
        chk_val("bp_lat17", 64'(got_cyc[0] - word_cyc[16]), 64'd1);
        chk_val("bp_b2_byte0", 64'(got_blk[2][7:0]), 64'(8'(272 * 7 + 3)));

        // Reset in the middle of a fill
        core_delay = 1;
        for (int i = 0; i < 5; i++) put_word(64'h0123_4567_89AB_CDEF + 64'(i), 1'b0, 4'd8);
        din_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk_blk("midrst_blk", blk, '0);
        chk_val("midrst_valid", 64'(blk_valid), 64'd0);
        chk_val("midrst_more", 64'(blk_more), 64'd0);
        chk_val("midrst_ready", 64'(din_ready), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        msg = {8'h61, 8'h62, 8'h63};
        run_msg(msg);
        chk_val("post_rst_nblk", 64'(got_blk.size()), 64'd1);
        chk_blk("post_rst_abc", got_blk[0], lit_abc);

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
